// File: rtl/sd_sector_streamer.sv
// Streams a run of consecutive SD sectors from sd_controller as a valid/ready byte stream.
// A sector read is only issued once the byte FIFO can absorb the whole sector.
module sd_sector_streamer #(
  parameter int FIFO_DEPTH   = 1024,
  parameter int SECTOR_BYTES = 512,
  parameter int BYTE_ADDR    = 1,
  parameter int TIMEOUT      = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [15:0] sector_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic        sd_ready,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(SECTOR_BYTES) + 1;

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, ISSUE, RECV, NEXT, FINISH} state_t;
  state_t r_state, w_next;

  logic [31:0]   r_sector, r_addr, r_tmo;
  logic [15:0]   r_count;
  logic [BW-1:0] r_bytes;
  logic          r_error, r_done, r_bav_q, r_wr_en, r_out_valid;
  logic [7:0]    r_wr_data, r_out_data;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];

  logic [PW-1:0] w_occ;
  logic          w_full, w_pop, w_wr_ok, w_edge, w_last, w_tmo;

  assign w_occ   = r_wptr - r_rptr;
  assign w_full  = (w_occ == PW'(FIFO_DEPTH));
  assign w_pop   = (w_occ != '0) && (!r_out_valid || out_ready);
  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign w_wr_ok = r_wr_en && (!w_full || w_pop);
  assign w_edge  = sd_byte_available && !r_bav_q;
  assign w_last  = w_edge && (r_bytes == BW'(SECTOR_BYTES - 1));
  assign w_tmo   = (r_tmo == 32'(TIMEOUT - 1));

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign error      = r_error;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign sd_rd      = (r_state == ISSUE);
  assign sd_address = r_addr;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       if (start) w_next = (sector_count == '0) ? FINISH : WAIT_SPACE;
      WAIT_SPACE: if (sd_ready && (w_occ <= PW'(FIFO_DEPTH - SECTOR_BYTES))) w_next = ISSUE;
      ISSUE: begin
        if (w_tmo)          w_next = FINISH;
        else if (!sd_ready) w_next = RECV;
      end
      RECV: begin
        if (w_last)     w_next = NEXT;
        else if (w_tmo) w_next = FINISH;
      end
      NEXT:       w_next = (r_count == 16'd1) ? FINISH : WAIT_SPACE;
      FINISH:     if (sd_ready) w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sector    <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_tmo       <= '0;
      r_bytes     <= '0;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_bav_q     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_bav_q   <= sd_byte_available;
      r_done    <= (r_state == FINISH) && sd_ready;
      r_wr_en   <= (r_state == RECV) && w_edge;
      r_wr_data <= sd_dout;

      if (r_state == IDLE && start) begin
        r_sector <= start_sector;
        r_count  <= sector_count;
        r_error  <= 1'b0;
      end

      if (r_state == WAIT_SPACE && w_next == ISSUE) begin
        r_addr  <= (BYTE_ADDR != 0) ? {r_sector[22:0], 9'd0} : r_sector;
        r_tmo   <= '0;
        r_bytes <= '0;
      end else if (r_state == ISSUE || r_state == RECV) begin
        r_tmo <= r_tmo + 32'd1;
      end

      if (r_state == RECV && w_edge) r_bytes <= r_bytes + BW'(1);
      if ((r_state == ISSUE || r_state == RECV) && w_next == FINISH) r_error <= 1'b1;

      if (r_state == NEXT) begin
        r_sector <= r_sector + 32'd1;
        r_count  <= r_count - 16'd1;
      end

      if (w_wr_ok)      r_wptr  <= r_wptr + PW'(1);
      else if (r_wr_en) r_error <= 1'b1;

      if (w_pop) begin
        r_out_data  <= r_mem[r_rptr[AW-1:0]];
        r_rptr      <= r_rptr + PW'(1);
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= r_wr_data;
  end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Scoreboard bench for sd_sector_streamer with a behavioural SPI sd_controller model.
// A second instance with sector addressing shares all inputs to check the SDHC address path.
module tb_sd_sector_streamer;

  localparam int TMO = 3000;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] sector_count = '0;
  logic        out_ready = 1'b0, sd_ready = 1'b1, sd_bav = 1'b0;
  logic [7:0]  sd_dout = '0;

  logic        busy, done, error, out_valid, sd_rd;
  logic [7:0]  out_data;
  logic [31:0] sd_address;
  logic        hc_busy, hc_done, hc_error, hc_out_valid, hc_sd_rd;
  logic [7:0]  hc_out_data;
  logic [31:0] hc_sd_address;

  sd_sector_streamer #(.FIFO_DEPTH(1024), .SECTOR_BYTES(512), .BYTE_ADDR(1), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .busy(busy), .done(done), .error(error),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sd_rd(sd_rd), .sd_address(sd_address), .sd_ready(sd_ready),
    .sd_byte_available(sd_bav), .sd_dout(sd_dout));

  sd_sector_streamer #(.FIFO_DEPTH(1024), .SECTOR_BYTES(512), .BYTE_ADDR(0), .TIMEOUT(TMO)) u_hc (
    .clk(clk), .reset(reset), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .busy(hc_busy), .done(hc_done), .error(hc_error),
    .out_valid(hc_out_valid), .out_data(hc_out_data), .out_ready(out_ready),
    .sd_rd(hc_sd_rd), .sd_address(hc_sd_address), .sd_ready(sd_ready),
    .sd_byte_available(sd_bav), .sd_dout(sd_dout));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int unsigned cyc = 0, n_issue = 0, n_rx = 0, n_done = 0, n_rd = 0;
  int unsigned hc_rx = 0, hc_ndone = 0, exp_total = 0;
  int unsigned exp_sum = 0, hc_sum = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr[$], exp_hc[$];
  bit card_mute = 1'b0, card_ab = 1'b0, hc_chk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dfn(input logic [31:0] a, input int unsigned i);
    return 8'(i) + 8'(a >> 9) * 8'd37 + 8'(i >> 8) * 8'd101 + 8'(a);
  endfunction

  task automatic push_sector(input logic [31:0] a);
    logic [7:0] b;
    exp_addr.push_back(a);
    for (int unsigned i = 0; i < 512; i++) begin
      b = dfn(a, i);
      exp_q.push_back(b);
      exp_sum += 32'(b);
      exp_total++;
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_data: got 0x%02h with no byte expected", out_data);
      end else begin
        check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (!reset && hc_out_valid && out_ready) begin
      hc_rx++;
      hc_sum += 32'(hc_out_data);
    end
    if (done)    n_done++;
    if (hc_done) hc_ndone++;
    if (sd_rd)   n_rd++;
  end

  task automatic tick();
    @(posedge clk);
    if (reset) card_ab = 1'b1;
    #1;
  endtask

  // Card model: accepts a read, drops ready, then strobes 512 bytes (2 high, 2 low).
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!reset && sd_rd && sd_ready) begin
        a = sd_address;
        n_issue++;
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL sd_address: got 0x%08h with no read expected", a);
        end else begin
          check("sd_address", a, exp_addr.pop_front());
        end
        if (hc_chk) begin
          check("hc_sd_rd", {31'd0, hc_sd_rd}, 32'd1);
          if (exp_hc.size() != 0) check("hc_sd_address", hc_sd_address, exp_hc.pop_front());
        end
        card_ab = 1'b0;
        tick();
        sd_ready = 1'b0;
        repeat (3) tick();
        if (card_mute) begin
          repeat (20) tick();
        end else begin
          for (int unsigned i = 0; i < 512 && !card_ab; i++) begin
            sd_dout = dfn(a, i);
            sd_bav  = 1'b1;
            tick(); tick();
            sd_bav  = 1'b0;
            tick(); tick();
          end
        end
        sd_bav   = 1'b0;
        sd_ready = 1'b1;
      end
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [15:0] c);
    start_sector = s;
    sector_count = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, input string nm);
    int unsigned k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (k == budget) begin
      errors++;
      $display("FAIL %s: done not seen, got none within %0d cycles, expected a pulse", nm, budget);
    end
  endtask

  task automatic wait_drain(input string nm);
    int unsigned k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    checks++;
    if (k == 3000) begin
      errors++;
      $display("FAIL %s: got %0d bytes still expected, expected 0", nm, exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_busy"},    {31'd0, busy},      32'd0);
    check({nm, "_done"},    {31'd0, done},      32'd0);
    check({nm, "_error"},   {31'd0, error},     32'd0);
    check({nm, "_valid"},   {31'd0, out_valid}, 32'd0);
    check({nm, "_sd_rd"},   {31'd0, sd_rd},     32'd0);
    check({nm, "_address"}, sd_address,         32'd0);
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation still running after 100000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, base2, t0, d;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single sector at sector 5, byte addressed
    base = n_rx; base2 = n_done;
    push_sector(32'h0000_0A00);
    do_start(32'd5, 16'd1);
    @(negedge clk);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(5000, "t1_done");
    check("t1_error", {31'd0, error}, 32'd0);
    wait_drain("t1_drain");
    check("t1_bytes", n_rx - base, 32'd512);
    check("t1_done_pulses", n_done - base2, 32'd1);

    // 2: consumer stalled: only two sectors fit in the buffer
    out_ready = 1'b0;
    base = n_rx; base2 = n_issue;
    push_sector(32'h0000_1400);
    push_sector(32'h0000_1600);
    push_sector(32'h0000_1800);
    do_start(32'd10, 16'd3);
    repeat (6000) @(negedge clk);
    check("t2_withheld_issues", n_issue - base2, 32'd2);
    check("t2_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    wait_done(10000, "t2_done");
    check("t2_issues", n_issue - base2, 32'd3);
    wait_drain("t2_drain");
    check("t2_bytes", n_rx - base, 32'd1536);

    // 3: zero-length run
    base = n_rd;
    do_start(32'd99, 16'd0);
    @(negedge clk);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_busy_off", {31'd0, busy}, 32'd0);
    check("t3_no_sd_rd", n_rd - base, 32'd0);

    // 4: card never returns bytes
    card_mute = 1'b1;
    base2 = n_issue;
    exp_addr.push_back(32'h0000_0E00);
    do_start(32'd7, 16'd2);
    for (int unsigned k = 0; k < 50; k++) begin
      @(negedge clk);
      if (sd_rd) break;
    end
    t0 = cyc;
    wait_done(5000, "t4_done");
    d = cyc - t0;
    checks++;
    if (d < TMO - 5 || d > TMO + 20) begin
      errors++;
      $display("FAIL t4_timeout_latency: got %0d cycles, expected about %0d", d, TMO);
    end
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_issues", n_issue - base2, 32'd1);
    card_mute = 1'b0;
    repeat (10) @(negedge clk);
    do_start(32'd0, 16'd0);
    @(negedge clk);
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    wait_done(20, "t4_clear_done");

    // 5: sector number wraps through zero
    hc_chk = 1'b1;
    push_sector(32'hFFFF_FE00);
    push_sector(32'h0000_0000);
    exp_hc.push_back(32'hFFFF_FFFF);
    exp_hc.push_back(32'h0000_0000);
    do_start(32'hFFFF_FFFF, 16'd2);
    wait_done(12000, "t5_done");
    check("t5_error", {31'd0, error}, 32'd0);
    check("t5_hc_addresses_left", exp_hc.size(), 32'd0);
    wait_drain("t5_drain");
    hc_chk = 1'b0;

    // 6: reset in the middle of the first sector of two
    out_ready = 1'b0;
    exp_addr.push_back(32'h0000_2800);
    do_start(32'd20, 16'd2);
    repeat (600) @(negedge clk);
    check("t6_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t6_reset");
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_fifo_dropped", {31'd0, out_valid}, 32'd0);
    base = n_rx;
    push_sector(32'h0000_0200);
    do_start(32'd1, 16'd1);
    wait_done(5000, "t6_done");
    check("t6_error", {31'd0, error}, 32'd0);
    wait_drain("t6_drain");
    check("t6_bytes", n_rx - base, 32'd512);

    check("hc_bytes", hc_rx, exp_total);
    check("hc_byte_sum", hc_sum, exp_sum);
    check("hc_done_pulses", hc_ndone, 32'd7);
    check("hc_idle", {30'd0, hc_busy, hc_error}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
